// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_pkg
//  Description : Shared types, widths and helpers for the microwave
//                time-entry front end (keypad FSM states, key/digit widths,
//                one-hot to BCD conversion).
//  Revision    : 1.0  initial release
// ============================================================================
package microwave_pkg;

  localparam int KEY_W   = 10;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_LOAD     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Bit i of a one-hot key vector maps to BCD digit i. Only one-hot values
  // reach this function, so the result is always 0-9.
  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] i_onehot);
    logic [DIGIT_W-1:0] w_bcd;
    w_bcd = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (i_onehot[i]) w_bcd = DIGIT_W'(i);
    end
    return w_bcd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous level inputs,
//                parameterized width, synchronous active-high clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_encoder
//  Description : Debounces ten one-hot digit keys and emits one BCD digit
//                with a single active-low load strobe per press.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_encoder
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [KEY_W-1:0]   keys,
  input  logic               enable,
  input  logic               clear_entry,
  output logic [DIGIT_W-1:0] data_out,
  output logic               loadn,
  output logic               busy,
  output logic [1:0]         digit_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0]   w_k;
  state_t             r_state;
  logic [KEY_W-1:0]   r_latched;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] r_data;
  logic               r_loadn;
  logic [1:0]         r_count;

  sync_2ff #(
    .WIDTH (KEY_W)
  ) u_key_sync (
    .clk (clock),
    .rst (clear),
    .i_d (keys),
    .o_q (w_k)
  );

  // Press/release FSM with debounce counter; loadn and data_out are
  // registered on the edge that enters LOAD so the strobe is glitch-free.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_latched <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_loadn   <= 1'b1;
      r_count   <= '0;
    end else begin
      r_loadn <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (enable && $onehot(w_k)) begin
            r_latched <= w_k;
            r_cnt     <= '0;
            r_state   <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!enable || (w_k != r_latched)) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == c_CNT_MAX) begin
            r_state <= ST_LOAD;
            r_loadn <= 1'b0;
            r_data  <= onehot_to_bcd(r_latched);
            if (r_count != 2'd3) r_count <= r_count + 2'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Other keys pressed while the first is held are ignored.
          if (w_k == '0) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_k != '0) begin
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end else if (r_cnt == c_CNT_MAX) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Placed after the FSM so it overrides a simultaneous increment.
      if (clear_entry) r_count <= '0;
    end
  end

  assign data_out    = r_data;
  assign loadn       = r_loadn;
  assign busy        = (r_state != ST_IDLE);
  assign digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_encoder
//  Description : Directed self-checking bench for keypad_encoder with
//                DEBOUNCE_CYCLES = 4 (press-to-strobe latency 7 clocks).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_encoder;

  logic       clock = 1'b0;
  logic       clear;
  logic [9:0] keys;
  logic       enable;
  logic       clear_entry;
  logic [3:0] data_out;
  logic       loadn;
  logic       busy;
  logic [1:0] digit_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  keypad_encoder #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (5)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .keys        (keys),
    .enable      (enable),
    .clear_entry (clear_entry),
    .data_out    (data_out),
    .loadn       (loadn),
    .busy        (busy),
    .digit_count (digit_count)
  );

  always #5 clock = ~clock;

  // Count strobe cycles on the inactive edge.
  always @(negedge clock) begin
    if (loadn === 1'b0) n_pulses++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Applies keys, then watches up to n cycles; reports the first cycle with
  // loadn low (0 if none) and how many low cycles were seen.
  task automatic press_watch(input logic [9:0] k, input int n,
                             output int first, output int lows);
    keys  = k;
    first = 0;
    lows  = 0;
    for (int c = 1; c <= n; c++) begin
      tick(1);
      if (loadn === 1'b0) begin
        lows++;
        if (first == 0) first = c;
      end
    end
  endtask

  initial begin
    int first, lows, p0;
    clear = 1'b1; keys = '0; enable = 1'b1; clear_entry = 1'b0;
    tick(3);
    check("rst_loadn", int'(loadn), 1);
    check("rst_data", int'(data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(digit_count), 0);
    clear = 1'b0;
    tick(2);

    // Clean press of key 7 held 20 cycles.
    press_watch(10'd1 << 7, 20, first, lows);
    check("k7_latency", first, 7);
    check("k7_lows", lows, 1);
    check("k7_data", int'(data_out), 7);
    check("k7_count", int'(digit_count), 1);
    keys = '0; tick(12);
    check("k7_idle", int'(busy), 0);

    // Key 3 bouncing, then stable; release bounce of one cycle.
    p0 = n_pulses;
    keys = 10'd1 << 3; tick(2);
    keys = '0;         tick(2);
    keys = 10'd1 << 3; tick(2);
    keys = '0;         tick(2);
    keys = 10'd1 << 3; tick(15);
    check("k3_pulses", n_pulses - p0, 1);
    check("k3_data", int'(data_out), 3);
    keys = '0;         tick(3);
    keys = 10'd1 << 3; tick(1);
    keys = '0;         tick(14);
    check("k3_relbounce", n_pulses - p0, 1);
    check("k3_idle", int'(busy), 0);

    // Keys 2 and 5 together, then 2 alone.
    p0 = n_pulses;
    keys = (10'd1 << 2) | (10'd1 << 5); tick(10);
    check("k25_pulses", n_pulses - p0, 0);
    check("k25_busy", int'(busy), 0);
    keys = 10'd1 << 2; tick(12);
    check("k2_pulses", n_pulses - p0, 1);
    check("k2_data", int'(data_out), 2);
    keys = '0; tick(12);

    // enable low while pressing 9; then enable drops mid-debounce.
    p0 = n_pulses;
    enable = 1'b0; keys = 10'd1 << 9; tick(12);
    check("en0_pulses", n_pulses - p0, 0);
    check("en0_busy", int'(busy), 0);
    keys = '0; enable = 1'b1; tick(4);
    keys = 10'd1 << 9; tick(4);
    check("endrop_busy_before", int'(busy), 1);
    enable = 1'b0; tick(1);
    check("endrop_busy_after", int'(busy), 0);
    tick(10);
    check("endrop_pulses", n_pulses - p0, 0);
    check("endrop_data", int'(data_out), 2);
    keys = '0; enable = 1'b1; tick(4);

    // Four presses: count 1,2,3 then clear_entry with the 4th load.
    clear_entry = 1'b1; tick(1); clear_entry = 1'b0;
    check("ce_count", int'(digit_count), 0);
    press_watch(10'd1 << 1, 10, first, lows); keys = '0; tick(12);
    check("cnt1", int'(digit_count), 1);
    press_watch(10'd1 << 4, 10, first, lows); keys = '0; tick(12);
    check("cnt2", int'(digit_count), 2);
    press_watch(10'd1 << 6, 10, first, lows); keys = '0; tick(12);
    check("cnt3", int'(digit_count), 3);
    press_watch(10'd1 << 8, 6, first, lows);
    clear_entry = 1'b1; tick(1);
    check("ce_load_pulse", int'(loadn), 0);
    tick(1);
    clear_entry = 1'b0; tick(1);
    check("ce_load_count", int'(digit_count), 0);
    check("ce_load_data", int'(data_out), 8);
    keys = '0; tick(12);

    // clear during HOLD, key still held afterwards counts as a new press.
    press_watch(10'd1 << 5, 12, first, lows);
    check("k5_hold_busy", int'(busy), 1);
    check("k5_data", int'(data_out), 5);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_loadn", int'(loadn), 1);
    check("clr_data", int'(data_out), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_count", int'(digit_count), 0);
    press_watch(10'd1 << 5, 10, first, lows);
    check("clr_repress_latency", first, 7);
    check("clr_repress_data", int'(data_out), 5);
    keys = '0; tick(12);
    check("final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
